thor2023_cache_fill: RTL and testbench

- Miss-handling and line-fill controller directly downstream of the cache hit detector.
- Consumes the detector's hit/way result, selects a victim way, and fetches the line from the bus in beats.
- Writes data beats, then the tag, into the cache RAMs.
- Owns the per-way valid-bit array that feeds back into the hit detector.

---
 rtl/thor2023_cache_fill.sv | 200 ++++++++++++++++++++
 tb/tb_thor2023_cache_fill.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thor2023_cache_fill.sv
// ============================================================================
// Module   : thor2023_cache_fill
// Purpose  : Miss handler and line-fill controller; owns the per-way valid bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module thor2023_cache_fill #(
    parameter int LINES  = 256,
    parameter int WAYS   = 4,
    parameter int AWID   = 32,
    parameter int TAGBIT = 14,
    parameter int BUSWID = 128,
    localparam int NDXW  = $clog2(LINES),
    localparam int WAYW  = $clog2(WAYS),
    localparam int OFFW  = TAGBIT - NDXW,
    localparam int BOFFW = $clog2(BUSWID / 8),
    localparam int BEATS = (1 << OFFW) / (BUSWID / 8),
    localparam int BEATW = $clog2(BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [AWID-1:0]       adr_i,
    input  logic                  hit_i,
    input  logic [WAYW-1:0]       rway_i,
    output logic                  busy_o,
    output logic [WAYS*LINES-1:0] valid_o,
    output logic                  bus_cyc_o,
    output logic [AWID-1:0]       bus_adr_o,
    input  logic                  bus_ack_i,
    input  logic                  bus_err_i,
    input  logic [BUSWID-1:0]     bus_dat_i,
    output logic                  wr_o,
    output logic [WAYW-1:0]       wr_way_o,
    output logic [NDXW-1:0]       wr_ndx_o,
    output logic [BEATW-1:0]      wr_beat_o,
    output logic [BUSWID-1:0]     wr_dat_o,
    output logic                  tag_wr_o,
    output logic [AWID-TAGBIT-1:0] tag_o,
    output logic                  fill_done_o,
    output logic                  fill_err_o,
    input  logic                  inv_all_i,
    input  logic                  inv_line_i,
    input  logic [AWID-1:0]       inv_adr_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [AWID-1:OFFW]      line_q;
    logic [WAYW-1:0]         vic_q;
    logic [WAYW-1:0]         vic_d;
    logic [WAYW-1:0]         ptr_q;
    logic                    from_ptr_q;
    logic                    from_ptr_d;
    logic                    kill_q;
    logic [BEATW-1:0]        beat_q;
    logic [BEATW-1:0]        wr_beat_q;
    logic [BUSWID-1:0]       dat_q;
    logic                    wr_q;
    logic                    tag_wr_q;
    logic                    done_q;
    logic                    err_q;
    logic [WAYS*LINES-1:0]   valid_q;
    logic [WAYS*LINES-1:0]   valid_d;

    logic                    miss;
    logic [NDXW-1:0]         req_ndx;
    logic [NDXW-1:0]         fill_ndx;
    logic [NDXW-1:0]         inv_ndx;
    logic                    unused_bits;

    assign miss     = (state_q == S_IDLE) & req_i & ~hit_i;
    assign req_ndx  = adr_i[TAGBIT-1:OFFW];
    assign fill_ndx = line_q[TAGBIT-1:OFFW];
    assign inv_ndx  = inv_adr_i[TAGBIT-1:OFFW];

    assign unused_bits = ^{rway_i, adr_i[OFFW-1:0], inv_adr_i[AWID-1:TAGBIT],
                           inv_adr_i[OFFW-1:0]};

    // Lowest empty way wins; a full set falls back to the round-robin pointer.
    always_comb begin
        vic_d      = ptr_q;
        from_ptr_d = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[{WAYW'(w), req_ndx}]) begin
                vic_d      = WAYW'(w);
                from_ptr_d = 1'b0;
            end
        end
    end

    // Invalidations are applied last so they override a same-cycle valid set.
    always_comb begin
        valid_d = valid_q;
        if (miss) begin
            valid_d[{vic_d, req_ndx}] = 1'b0;
        end
        if ((state_q == S_UPDATE) && !kill_q) begin
            valid_d[{vic_q, fill_ndx}] = 1'b1;
        end
        if (inv_line_i) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_d[{WAYW'(w), inv_ndx}] = 1'b0;
            end
        end
        if (inv_all_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            line_q     <= '0;
            vic_q      <= '0;
            ptr_q      <= '0;
            from_ptr_q <= 1'b0;
            kill_q     <= 1'b0;
            beat_q     <= '0;
            wr_beat_q  <= '0;
            dat_q      <= '0;
            wr_q       <= 1'b0;
            tag_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            valid_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_q     <= 1'b0;
            tag_wr_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;

            if ((state_q != S_IDLE) && inv_line_i && (inv_ndx == fill_ndx)) begin
                kill_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (miss) begin
                        line_q     <= adr_i[AWID-1:OFFW];
                        vic_q      <= vic_d;
                        from_ptr_q <= from_ptr_d;
                        beat_q     <= '0;
                        kill_q     <= 1'b0;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus_err_i) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (bus_ack_i) begin
                        dat_q     <= bus_dat_i;
                        wr_q      <= 1'b1;
                        wr_beat_q <= beat_q;
                        beat_q    <= beat_q + 1'b1;
                        if (beat_q == BEATW'(BEATS - 1)) begin
                            tag_wr_q <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= S_UPDATE;
                        end
                    end
                end
                S_UPDATE: begin
                    if (from_ptr_q) begin
                        ptr_q <= (ptr_q == WAYW'(WAYS - 1)) ? '0 : ptr_q + 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = (state_q != S_IDLE) | miss;
    assign valid_o     = valid_q;
    assign bus_cyc_o   = (state_q == S_FETCH);
    assign bus_adr_o   = {line_q, beat_q, {BOFFW{1'b0}}};
    assign wr_o        = wr_q;
    assign wr_way_o    = vic_q;
    assign wr_ndx_o    = fill_ndx;
    assign wr_beat_o   = wr_beat_q;
    assign wr_dat_o    = dat_q;
    assign tag_wr_o    = tag_wr_q;
    assign tag_o       = line_q[AWID-1:TAGBIT];
    assign fill_done_o = done_q;
    assign fill_err_o  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_thor2023_cache_fill.sv
// ============================================================================
// Module   : tb_thor2023_cache_fill
// Purpose  : Directed and random bench with a transaction-level fill model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_thor2023_cache_fill;

    localparam int NBEAT = 4;

    logic         clk;
    logic         rst;
    logic         req_i;
    logic [31:0]  adr_i;
    logic         hit_i;
    logic [1:0]   rway_i;
    logic         busy_o;
    logic [1023:0] valid_o;
    logic         bus_cyc_o;
    logic [31:0]  bus_adr_o;
    logic         bus_ack_i;
    logic         bus_err_i;
    logic [127:0] bus_dat_i;
    logic         wr_o;
    logic [1:0]   wr_way_o;
    logic [7:0]   wr_ndx_o;
    logic [1:0]   wr_beat_o;
    logic [127:0] wr_dat_o;
    logic         tag_wr_o;
    logic [17:0]  tag_o;
    logic         fill_done_o;
    logic         fill_err_o;
    logic         inv_all_i;
    logic         inv_line_i;
    logic [31:0]  inv_adr_i;

    thor2023_cache_fill dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .adr_i       (adr_i),
        .hit_i       (hit_i),
        .rway_i      (rway_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .bus_cyc_o   (bus_cyc_o),
        .bus_adr_o   (bus_adr_o),
        .bus_ack_i   (bus_ack_i),
        .bus_err_i   (bus_err_i),
        .bus_dat_i   (bus_dat_i),
        .wr_o        (wr_o),
        .wr_way_o    (wr_way_o),
        .wr_ndx_o    (wr_ndx_o),
        .wr_beat_o   (wr_beat_o),
        .wr_dat_o    (wr_dat_o),
        .tag_wr_o    (tag_wr_o),
        .tag_o       (tag_o),
        .fill_done_o (fill_done_o),
        .fill_err_o  (fill_err_o),
        .inv_all_i   (inv_all_i),
        .inv_line_i  (inv_line_i),
        .inv_adr_i   (inv_adr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cache valid map, replacement pointer, current fill record.
    bit           mv [4][256];
    int           rr;
    bit           f_fetch, f_upd, f_ptr, f_kill;
    logic [31:0]  f_adr;
    int           f_way, f_beats;
    bit           e_wr, e_tag, e_done, e_err;
    int           e_beat;
    logic [127:0] e_dat;

    int           lg_busy, lg_wr, lg_tag, lg_done, lg_err;
    int           q_adr[$];
    int           q_beat[$];
    int           q_way[$];
    logic [7:0]   last_ndx;
    logic [17:0]  last_tag;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 4; w++)
            for (int l = 0; l < 256; l++) mv[w][l] = 1'b0;
        rr = 0; f_fetch = 0; f_upd = 0; f_ptr = 0; f_kill = 0;
        f_adr = '0; f_way = 0; f_beats = 0;
        e_wr = 0; e_tag = 0; e_done = 0; e_err = 0; e_beat = 0; e_dat = '0;
    endtask

    task automatic clear_logs();
        lg_busy = 0; lg_wr = 0; lg_tag = 0; lg_done = 0; lg_err = 0;
        q_adr.delete(); q_beat.delete(); q_way.delete();
        last_ndx = '0; last_tag = '0;
    endtask

    task automatic compare();
        logic [1023:0] ev;
        for (int w = 0; w < 4; w++)
            for (int l = 0; l < 256; l++) ev[w*256 + l] = mv[w][l];
        check("busy", busy_o, f_fetch || f_upd || (req_i && !hit_i));
        check("bus_cyc", bus_cyc_o, f_fetch);
        if (f_fetch) check("bus_adr", bus_adr_o, (f_adr & ~32'h3F) + 32'(f_beats * 16));
        check("wr", wr_o, e_wr);
        if (e_wr) begin
            check("wr_beat", wr_beat_o, e_beat);
            check("wr_way", wr_way_o, f_way);
            check("wr_ndx", wr_ndx_o, f_adr[13:6]);
            check("wr_dat", wr_dat_o, e_dat);
        end
        check("tag_wr", tag_wr_o, e_tag);
        if (e_tag) check("tag", tag_o, f_adr[31:14]);
        check("fill_done", fill_done_o, e_done);
        check("fill_err", fill_err_o, e_err);
        check("valid_diff_bits", $countones(valid_o ^ ev), 0);
    endtask

    task automatic log_outputs();
        if (busy_o) lg_busy++;
        if (bus_cyc_o && bus_ack_i && !bus_err_i) q_adr.push_back(int'(bus_adr_o));
        if (wr_o) begin
            lg_wr++;
            q_beat.push_back(int'(wr_beat_o));
            q_way.push_back(int'(wr_way_o));
            last_ndx = wr_ndx_o;
        end
        if (tag_wr_o) begin
            lg_tag++;
            last_tag = tag_o;
        end
        if (fill_done_o) lg_done++;
        if (fill_err_o) lg_err++;
    endtask

    // What the controller must do at the coming clock edge, stated per fill phase.
    task automatic model_step(input bit req, input logic [31:0] adr, input bit hit,
                              input bit ack, input bit err, input logic [127:0] dat,
                              input bit iall, input bit iline, input logic [31:0] iadr);
        int v;
        e_wr = 0; e_tag = 0; e_done = 0; e_err = 0;
        if (f_fetch) begin
            if (iline && iadr[13:6] == f_adr[13:6]) f_kill = 1;
            if (err) begin
                e_err = 1;
                f_fetch = 0;
            end else if (ack) begin
                e_wr = 1; e_beat = f_beats; e_dat = dat;
                f_beats++;
                if (f_beats == NBEAT) begin
                    f_fetch = 0; f_upd = 1; e_tag = 1; e_done = 1;
                end
            end
        end else if (f_upd) begin
            if (!f_kill) mv[f_way][f_adr[13:6]] = 1;
            if (f_ptr) rr = (rr + 1) % 4;
            f_upd = 0;
        end else if (req && !hit) begin
            v = -1;
            for (int w = 0; w < 4; w++)
                if (!mv[w][adr[13:6]] && v < 0) v = w;
            f_ptr = (v < 0);
            if (v < 0) v = rr;
            mv[v][adr[13:6]] = 0;
            f_adr = adr; f_way = v; f_beats = 0; f_kill = 0; f_fetch = 1;
        end
        if (iline)
            for (int w = 0; w < 4; w++) mv[w][iadr[13:6]] = 0;
        if (iall)
            for (int w = 0; w < 4; w++)
                for (int l = 0; l < 256; l++) mv[w][l] = 0;
    endtask

    task automatic tick(input bit req, input logic [31:0] adr, input bit hit,
                        input bit ack, input bit err, input logic [127:0] dat,
                        input bit iall, input bit iline, input logic [31:0] iadr);
        req_i = req; adr_i = adr; hit_i = hit; rway_i = 2'($urandom);
        bus_ack_i = ack; bus_err_i = err; bus_dat_i = dat;
        inv_all_i = iall; inv_line_i = iline; inv_adr_i = iadr;
        #1;
        compare();
        log_outputs();
        model_step(req, adr, hit, ack, err, dat, iall, iline, iadr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(0, 32'h0, 0, 0, 0, rd(), 0, 0, 32'h0);
    endtask

    task automatic fill(input logic [31:0] a, input int gap);
        tick(1, a, 0, 0, 0, rd(), 0, 0, 32'h0);
        for (int b = 0; b < NBEAT; b++) begin
            repeat (gap) idle();
            tick(0, 32'h0, 0, 1, 0, rd(), 0, 0, 32'h0);
        end
        idle();
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_i = 0; adr_i = '0; hit_i = 0; rway_i = '0; bus_ack_i = 0; bus_err_i = 0;
        bus_dat_i = '0; inv_all_i = 0; inv_line_i = 0; inv_adr_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    int way_of [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_bus_cyc", bus_cyc_o, 0);
        check("rst_wr", wr_o, 0);
        check("rst_tag_wr", tag_wr_o, 0);
        check("rst_done_err", {fill_done_o, fill_err_o}, 0);
        check("rst_valid_count", $countones(valid_o), 0);
        @(posedge clk);
        #1;

        // Single miss into an empty set, back-to-back acks
        clear_logs();
        fill(32'h0000_1040, 0);
        check("d1_busy_cycles", lg_busy, 6);
        check("d1_bus_adrs", {q_adr.size(), 32'(q_adr[0]), 32'(q_adr[1]), 32'(q_adr[2]), 32'(q_adr[3])},
              {4, 32'h1040, 32'h1050, 32'h1060, 32'h1070});
        check("d1_wr_count", lg_wr, 4);
        check("d1_wr_beats", {q_beat[0], q_beat[1], q_beat[2], q_beat[3]}, {32'd0, 32'd1, 32'd2, 32'd3});
        check("d1_wr_way", q_way[0], 0);
        check("d1_wr_ndx", last_ndx, 8'h41);
        check("d1_tag", {lg_tag, 14'h0, last_tag}, {32'd1, 32'h0});
        check("d1_valid_0_41", valid_o[0*256 + 8'h41], 1);

        // Six misses into set 5: four empty ways, then round-robin
        for (int t = 1; t <= 6; t++) begin
            clear_logs();
            fill({18'(t), 8'h05, 6'h0}, 0);
            way_of[t] = q_way[0];
        end
        check("d2_ways_1_4", {way_of[1], way_of[2], way_of[3], way_of[4]}, {32'd0, 32'd1, 32'd2, 32'd3});
        check("d2_way_5th", way_of[5], 0);
        check("d2_way_6th", way_of[6], 1);

        // Bus error on beat 2, coinciding with an ack
        clear_logs();
        tick(1, 32'h0000_2080, 0, 0, 0, rd(), 0, 0, 32'h0);
        tick(0, 32'h0, 0, 1, 0, rd(), 0, 0, 32'h0);
        tick(0, 32'h0, 0, 1, 0, rd(), 0, 0, 32'h0);
        tick(0, 32'h0, 0, 1, 1, rd(), 0, 0, 32'h0);
        idle();
        idle();
        check("d3_wr_count", lg_wr, 2);
        check("d3_err_done_tag", {lg_err, lg_done, lg_tag}, {32'd1, 32'd0, 32'd0});
        check("d3_valid_0_82", valid_o[0*256 + 8'h82], 0);
        check("d3_idle", {busy_o, bus_cyc_o}, 0);

        // Same-set invalidate during beat 1 kills the final valid set
        clear_logs();
        tick(1, 32'h0000_30C0, 0, 0, 0, rd(), 0, 0, 32'h0);
        tick(0, 32'h0, 0, 1, 0, rd(), 0, 0, 32'h0);
        tick(0, 32'h0, 0, 1, 0, rd(), 0, 1, 32'h0001_F0C0);
        tick(0, 32'h0, 0, 1, 0, rd(), 0, 0, 32'h0);
        tick(0, 32'h0, 0, 1, 0, rd(), 0, 0, 32'h0);
        idle();
        idle();
        check("d4_done", lg_done, 1);
        check("d4_valid_0_c3", valid_o[0*256 + 8'hC3], 0);

        // Hit: no stall, no bus traffic
        clear_logs();
        tick(1, 32'h0000_1040, 1, 0, 0, rd(), 0, 0, 32'h0);
        check("d6_hit_quiet", {lg_busy, q_adr.size()}, 0);

        // Three idle cycles between acks
        clear_logs();
        fill(32'h0000_4100, 3);
        check("d6_gap_beats", {q_beat.size(), q_beat[0], q_beat[1], q_beat[2], q_beat[3]},
              {32'd4, 32'd0, 32'd1, 32'd2, 32'd3});
        check("d6_gap_busy", lg_busy, 18);

        // Reach ten valid lines, then invalidate everything
        for (int n = 0; n < 4; n++) fill({18'h7, 8'(8'h10 + n), 6'h0}, 0);
        check("d5_valid_count", $countones(valid_o), 10);
        tick(0, 32'h0, 0, 0, 0, rd(), 1, 0, 32'h0);
        check("d5_inv_all", $countones(valid_o), 0);

        // Reset mid-fill abandons it silently
        tick(1, 32'h0000_5140, 0, 0, 0, rd(), 0, 0, 32'h0);
        tick(0, 32'h0, 0, 1, 0, rd(), 0, 0, 32'h0);
        tick(0, 32'h0, 0, 1, 0, rd(), 0, 0, 32'h0);
        do_reset();
        clear_logs();
        repeat (6) idle();
        check("rstmid_quiet", {lg_done, lg_err, lg_wr}, 0);
        check("rstmid_valid", $countones(valid_o), 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [7:0]  ndx;
            logic [31:0] a;
            logic [31:0] ia;
            int sel;
            sel = $urandom_range(0, 3);
            ndx = (sel == 0) ? 8'h05 : (sel == 1) ? 8'h41 : (sel == 2) ? 8'h06 : 8'($urandom);
            a   = {18'($urandom_range(0, 7)), ndx, 6'($urandom)};
            ia  = ($urandom_range(0, 1) != 0) ? f_adr : {18'($urandom), 8'($urandom_range(0, 7)), 6'h0};
            tick($urandom_range(0, 2) != 0, a, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0, rd(),
                 $urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0, ia);
        end
        repeat (4) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
